// File: rtl/stack_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : stack_arbiter
// Description : Shares a single hardware stack between two requesters.
//               A (call/return unit) and B (data push/pop) are arbitrated
//               round-robin, with A holding priority out of reset. The block
//               tracks occupancy, refuses pushes when full and pops when
//               empty, and returns a registered one-cycle response to each
//               requester one cycle after its request is accepted. It is the
//               only driver of the stack's enable, direction, data-in and
//               pointer reset.
//
// Parameters  : DATA_WIDTH - width of stack entries and request/response data
//               PTR_WIDTH  - stack pointer width; capacity is 2**PTR_WIDTH-1
//                            (slot 0 of the stack is never written)
//
// Ports       : clk                      clock, all logic on rising edge
//               reset                    synchronous, active-high
//               a_req_valid/push/data    requester A request (push=1, pop=0)
//               a_req_ready              A request accepted this cycle
//               a_rsp_valid/data/err     A response, one-cycle pulse
//               b_req_* / b_rsp_*        same as A, for requester B
//               stack_en                 stack enable, one cycle per real op
//               stack_push               stack direction (1=push, 0=pop)
//               stack_din                stack data in
//               stack_dout               stack data out (current top)
//               stack_rst                stack pointer reset
//               depth                    current occupancy 0..capacity
//               full / empty             depth at capacity / depth is zero
//
// Revision    : 1.0 - initial release
// ============================================================================
module stack_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  a_req_valid,
    input  logic                  a_req_push,
    input  logic [DATA_WIDTH-1:0] a_req_data,
    output logic                  a_req_ready,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_data,
    output logic                  a_rsp_err,

    input  logic                  b_req_valid,
    input  logic                  b_req_push,
    input  logic [DATA_WIDTH-1:0] b_req_data,
    output logic                  b_req_ready,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_data,
    output logic                  b_rsp_err,

    output logic                  stack_en,
    output logic                  stack_push,
    output logic [DATA_WIDTH-1:0] stack_din,
    input  logic [DATA_WIDTH-1:0] stack_dout,
    output logic                  stack_rst,

    output logic [PTR_WIDTH-1:0]  depth,
    output logic                  full,
    output logic                  empty
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0]           c_ST_FLUSH = 1'b0;
    localparam logic [0:0]           c_ST_RUN   = 1'b1;

    // Capacity is all-ones in the pointer width (slot 0 is unused).
    localparam logic [PTR_WIDTH-1:0] c_CAP      = {PTR_WIDTH{1'b1}};
    localparam logic [PTR_WIDTH-1:0] c_ONE      = {{(PTR_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [0:0]            r_state;
    logic                  r_prio_b;      // 0: A wins a tie, 1: B wins a tie
    logic [PTR_WIDTH-1:0]  r_depth;
    logic                  r_full;
    logic                  r_empty;

    logic                  r_a_rsp_valid;
    logic                  r_a_rsp_err;
    logic [DATA_WIDTH-1:0] r_a_rsp_data;
    logic                  r_b_rsp_valid;
    logic                  r_b_rsp_err;
    logic [DATA_WIDTH-1:0] r_b_rsp_data;

    // ------------------------------------------------------------------------
    // Combinational arbitration and operation decode
    // ------------------------------------------------------------------------
    logic                  w_run;
    logic                  w_grant_a;
    logic                  w_grant_b;
    logic                  w_grant_any;
    logic                  w_op_push;
    logic [DATA_WIDTH-1:0] w_op_data;
    logic                  w_op_err;
    logic                  w_do_push;
    logic                  w_do_pop;
    logic [PTR_WIDTH-1:0]  w_depth_nxt;

    // Requests are accepted only in RUN and never while reset is asserted,
    // so an op presented in the reset cycle is dropped without a response.
    assign w_run = (r_state == c_ST_RUN) && !reset;

    always_comb begin
        w_grant_a   = 1'b0;
        w_grant_b   = 1'b0;
        w_grant_any = 1'b0;
        w_op_push   = 1'b0;
        w_op_data   = '0;
        w_op_err    = 1'b0;
        w_do_push   = 1'b0;
        w_do_pop    = 1'b0;
        w_depth_nxt = r_depth;

        if (w_run) begin
            // A lone requester always wins; on a tie the pointer decides.
            w_grant_a = a_req_valid && (!b_req_valid || !r_prio_b);
            w_grant_b = b_req_valid && (!a_req_valid ||  r_prio_b);
        end

        w_grant_any = w_grant_a || w_grant_b;

        if (w_grant_a) begin
            w_op_push = a_req_push;
            w_op_data = a_req_data;
        end else if (w_grant_b) begin
            w_op_push = b_req_push;
            w_op_data = b_req_data;
        end

        // Overflow / underflow are judged against the registered flags, so
        // back-to-back grants always see the effect of the previous op.
        if (w_grant_any) begin
            w_op_err = w_op_push ? r_full : r_empty;
        end

        w_do_push = w_grant_any &&  w_op_push && !w_op_err;
        w_do_pop  = w_grant_any && !w_op_push && !w_op_err;

        if (w_do_push) begin
            w_depth_nxt = r_depth + c_ONE;
        end else if (w_do_pop) begin
            w_depth_nxt = r_depth - c_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Sequential state: mode, priority pointer, occupancy, responses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_FLUSH;
            r_prio_b      <= 1'b0;
            r_depth       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_a_rsp_valid <= 1'b0;
            r_a_rsp_err   <= 1'b0;
            r_a_rsp_data  <= '0;
            r_b_rsp_valid <= 1'b0;
            r_b_rsp_err   <= 1'b0;
            r_b_rsp_data  <= '0;
        end else begin
            // FLUSH is a single cycle that holds the stack pointer in reset
            // after the external reset has been released.
            case (r_state)
                c_ST_FLUSH: r_state <= c_ST_RUN;
                c_ST_RUN:   r_state <= c_ST_RUN;
                default:    r_state <= c_ST_FLUSH;
            endcase

            // The pointer hands the tie-break to the side that was not served.
            if (w_grant_a) begin
                r_prio_b <= 1'b1;
            end else if (w_grant_b) begin
                r_prio_b <= 1'b0;
            end

            r_depth <= w_depth_nxt;
            r_full  <= (w_depth_nxt == c_CAP);
            r_empty <= (w_depth_nxt == '0);

            // Pop data is the pre-pop top of stack, captured in the grant
            // cycle; pushes and errors return zero.
            r_a_rsp_valid <= w_grant_a;
            r_a_rsp_err   <= w_grant_a && w_op_err;
            r_a_rsp_data  <= (w_grant_a && w_do_pop) ? stack_dout : '0;

            r_b_rsp_valid <= w_grant_b;
            r_b_rsp_err   <= w_grant_b && w_op_err;
            r_b_rsp_data  <= (w_grant_b && w_do_pop) ? stack_dout : '0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign a_req_ready = w_grant_a;
    assign b_req_ready = w_grant_b;

    assign a_rsp_valid = r_a_rsp_valid;
    assign a_rsp_err   = r_a_rsp_err;
    assign a_rsp_data  = r_a_rsp_data;
    assign b_rsp_valid = r_b_rsp_valid;
    assign b_rsp_err   = r_b_rsp_err;
    assign b_rsp_data  = r_b_rsp_data;

    // Direction and data are forced to zero whenever the stack is idle.
    assign stack_en    = w_do_push || w_do_pop;
    assign stack_push  = w_do_push;
    assign stack_din   = w_do_push ? w_op_data : '0;
    assign stack_rst   = reset || (r_state == c_ST_FLUSH);

    assign depth       = r_depth;
    assign full        = r_full;
    assign empty       = r_empty;

endmodule
`default_nettype wire
